// File: rtl/tt_mask_idx_rx.sv
// Mask/index receive queue and element sequencer.
// Buffers mask words or (mask, index) items from the transmitter and presents
// one element per accept to the consumer. Every pop returns one credit.
//
//    state     | meaning
//    ----------+-----------------------------------------------------------
//    ST_IDLE   | no op in flight; queue may still fill from the transmitter
//    ST_ACTIVE | op in flight; elements presented while the queue has data
module tt_mask_idx_rx #(
   parameter int VLEN         = 256,
   parameter int MASK_CREDITS = 2
) (
   input  logic                        i_clk,
   input  logic                        i_reset_n,
   input  logic                        i_mask_idx_valid,
   input  logic [64:0]                 i_mask_idx_item,
   input  logic                        i_mask_idx_last_idx,
   input  logic                        i_op_start,
   input  logic                        i_is_indexed,
   input  logic [$clog2(VLEN+1)-1:0]   i_vl,
   input  logic                        i_elem_req,
   output logic                        o_elem_valid,
   output logic                        o_elem_mask,
   output logic [63:0]                 o_elem_index,
   output logic                        o_elem_last,
   output logic                        o_mask_idx_credit,
   output logic                        o_busy,
   output logic                        o_err
);

   localparam int VLW = $clog2(VLEN + 1);
   localparam int PW  = (MASK_CREDITS > 1) ? $clog2(MASK_CREDITS) : 1;
   localparam int CW  = $clog2(MASK_CREDITS + 1);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [65:0]      mem_q [MASK_CREDITS];
   logic [65:0]      mem_d [MASK_CREDITS];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             mode_q, mode_d;
   logic [VLW-1:0]   vl_q, vl_d;
   logic [VLW-1:0]   cnt_q, cnt_d;
   logic [5:0]       bptr_q, bptr_d;
   logic             err_q, err_d;
   logic             credit_q, credit_d;

   logic [65:0]      head;
   logic [63:0]      head_word;
   logic             head_mask;
   logic             head_last;
   logic             fifo_full;
   logic             fifo_empty;
   logic             elem_valid;
   logic             elem_last;
   logic             accept;
   logic             pop;
   logic             push_ok;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MASK_CREDITS - 1)) ? '0 : p + PW'(1);
   endfunction

   // Queue head decode and the accept/pop/push handshake terms.
   always_comb begin
      head       = mem_q[rd_ptr_q];
      head_mask  = head[65];
      head_word  = head[64:1];
      head_last  = head[0];
      fifo_full  = (count_q == CW'(MASK_CREDITS));
      fifo_empty = (count_q == '0);
      // Gating with reset keeps the consumer handshake quiet while reset is held.
      elem_valid = i_reset_n && (state_q == ST_ACTIVE) && !fifo_empty;
      elem_last  = (cnt_q == (vl_q - VLW'(1)));
      accept     = elem_valid && i_elem_req;
      // A strided mask word is consumed after bit 63 or at the op's final element.
      pop        = accept && (mode_q || (bptr_q == 6'd63) || elem_last);
      // When full, a same-cycle pop frees the slot the push needs.
      push_ok    = i_mask_idx_valid && (!fifo_full || pop);
   end

   // Queue storage, pointers and occupancy.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = {i_mask_idx_item, i_mask_idx_last_idx};
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push_ok && !pop) begin
         count_d = count_q + CW'(1);
      end else if (!push_ok && pop) begin
         count_d = count_q - CW'(1);
      end
   end

   // Op state machine next-state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (i_op_start && (i_vl != '0)) begin
               state_d = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (accept && elem_last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Op context, element counter, bit pointer, sticky error and credit pulse.
   always_comb begin
      mode_d   = mode_q;
      vl_d     = vl_q;
      cnt_d    = cnt_q;
      bptr_d   = bptr_q;
      err_d    = err_q;
      credit_d = pop;

      if (state_q == ST_IDLE) begin
         if (i_op_start && (i_vl != '0)) begin
            mode_d = i_is_indexed;
            vl_d   = i_vl;
            cnt_d  = '0;
            bptr_d = '0;
         end
      end else begin
         if (i_op_start) begin
            err_d = 1'b1;
         end
         if (accept) begin
            cnt_d = cnt_q + VLW'(1);
            if (!mode_q) begin
               bptr_d = pop ? 6'd0 : bptr_q + 6'd1;
            end
         end
      end

      if (i_mask_idx_valid && fifo_full && !pop) begin
         err_d = 1'b1;
      end
      if (accept && mode_q && (head_last != elem_last)) begin
         err_d = 1'b1;
      end
   end

   // Register update with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q  <= ST_IDLE;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         mode_q   <= 1'b0;
         vl_q     <= '0;
         cnt_q    <= '0;
         bptr_q   <= '0;
         err_q    <= 1'b0;
         credit_q <= 1'b0;
         for (int i = 0; i < MASK_CREDITS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         mode_q   <= mode_d;
         vl_q     <= vl_d;
         cnt_q    <= cnt_d;
         bptr_q   <= bptr_d;
         err_q    <= err_d;
         credit_q <= credit_d;
         for (int i = 0; i < MASK_CREDITS; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   // Element presentation; strided ops report a zero index.
   always_comb begin
      o_elem_valid      = elem_valid;
      o_elem_mask       = 1'b0;
      o_elem_index      = '0;
      o_elem_last       = 1'b0;
      if (elem_valid) begin
         o_elem_mask  = mode_q ? head_mask : head_word[bptr_q];
         o_elem_index = mode_q ? head_word : 64'd0;
         o_elem_last  = elem_last;
      end
      o_mask_idx_credit = credit_q;
      o_busy            = (state_q == ST_ACTIVE);
      o_err             = err_q;
   end

endmodule

// File: tb/tb_tt_mask_idx_rx.sv
// Directed bench for tt_mask_idx_rx with hand-computed expected elements.
module tb_tt_mask_idx_rx;

   localparam int VLW = 9;

   logic            clk;
   logic            rst_n;
   logic            push_valid;
   logic [64:0]     push_item;
   logic            push_last;
   logic            op_start;
   logic            is_indexed;
   logic [VLW-1:0]  vl;
   logic            elem_req;
   logic            o_elem_valid;
   logic            o_elem_mask;
   logic [63:0]     o_elem_index;
   logic            o_elem_last;
   logic            o_mask_idx_credit;
   logic            o_busy;
   logic            o_err;

   int total = 0;
   int bad   = 0;

   logic [64:0] items_tb [8];
   logic        lasts_tb [8];

   tt_mask_idx_rx #(.VLEN(256), .MASK_CREDITS(2)) dut (
      .i_clk               (clk),
      .i_reset_n           (rst_n),
      .i_mask_idx_valid    (push_valid),
      .i_mask_idx_item     (push_item),
      .i_mask_idx_last_idx (push_last),
      .i_op_start          (op_start),
      .i_is_indexed        (is_indexed),
      .i_vl                (vl),
      .i_elem_req          (elem_req),
      .o_elem_valid        (o_elem_valid),
      .o_elem_mask         (o_elem_mask),
      .o_elem_index        (o_elem_index),
      .o_elem_last         (o_elem_last),
      .o_mask_idx_credit   (o_mask_idx_credit),
      .o_busy              (o_busy),
      .o_err               (o_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      push_valid = 1'b0;
      push_item  = '0;
      push_last  = 1'b0;
      op_start   = 1'b0;
      is_indexed = 1'b0;
      vl         = '0;
      elem_req   = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      idle_inputs();
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   // Runs one op with an always-ready consumer and a credit-limited transmitter.
   task automatic run_op(input string name, input bit is_idx, input int vl_in, input int n_items);
      int e = 0;
      int ncred = 0;
      int credits = 2;
      int sent = 0;
      int cycles = 0;
      bit first = 1'b1;
      logic [64:0] w;
      while (1) begin
         cyc();
         op_start   = first;
         is_indexed = is_idx;
         vl         = VLW'(vl_in);
         first      = 1'b0;
         if (sent < n_items && credits > 0) begin
            push_valid = 1'b1;
            push_item  = items_tb[sent];
            push_last  = lasts_tb[sent];
            sent++;
            credits--;
         end else begin
            push_valid = 1'b0;
         end
         elem_req = 1'b1;
         @(negedge clk);
         if (o_elem_valid) begin
            if (is_idx) begin
               w = items_tb[e % 8];
               chk({name, "_mask"}, 64'(o_elem_mask), 64'(w[64]));
               chk({name, "_index"}, o_elem_index, w[63:0]);
            end else begin
               w = items_tb[(e / 64) % 8];
               chk({name, "_mask"}, 64'(o_elem_mask), 64'(w[e % 64]));
               chk({name, "_index"}, o_elem_index, 64'd0);
            end
            chk({name, "_last"}, 64'(o_elem_last), 64'(e == vl_in - 1));
            e++;
         end
         if (o_mask_idx_credit) begin
            credits++;
            ncred++;
         end
         cycles++;
         if ((e >= vl_in && ncred >= n_items && !o_busy) || cycles > 600) break;
      end
      idle_inputs();
      chk({name, "_timeout"}, 64'(cycles > 600), 64'd0);
      chk({name, "_n_elem"}, 64'(e), 64'(vl_in));
      chk({name, "_n_credit"}, 64'(ncred), 64'(n_items));
      chk({name, "_busy_end"}, 64'(o_busy), 64'd0);
      chk({name, "_err"}, 64'(o_err), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();

      // Reset state
      cyc();
      @(negedge clk);
      chk("rst_valid", 64'(o_elem_valid), 64'd0);
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_err", 64'(o_err), 64'd0);
      chk("rst_credit", 64'(o_mask_idx_credit), 64'd0);
      apply_reset();

      // Strided, vl=130
      items_tb[0] = {1'b0, 64'hFFFF_FFFF_FFFF_FFFF}; lasts_tb[0] = 1'b0;
      items_tb[1] = {1'b0, 64'h0};                   lasts_tb[1] = 1'b0;
      items_tb[2] = {1'b0, 64'h3};                   lasts_tb[2] = 1'b1;
      run_op("strided", 1'b0, 130, 3);

      // Indexed, vl=3
      items_tb[0] = {1'b1, 64'h10}; lasts_tb[0] = 1'b0;
      items_tb[1] = {1'b0, 64'h20}; lasts_tb[1] = 1'b0;
      items_tb[2] = {1'b1, 64'h30}; lasts_tb[2] = 1'b1;
      run_op("indexed", 1'b1, 3, 3);

      // Backpressure with 2 items queued
      apply_reset();
      push_valid = 1'b1; push_item = {1'b1, 64'hAB}; push_last = 1'b0;
      cyc();
      push_item = {1'b0, 64'hCD}; push_last = 1'b1;
      cyc();
      push_valid = 1'b0; push_item = '0; push_last = 1'b0;
      op_start = 1'b1; is_indexed = 1'b1; vl = VLW'(2);
      cyc();
      op_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", 64'(o_elem_valid), 64'd1);
         chk("bp_mask", 64'(o_elem_mask), 64'd1);
         chk("bp_index", o_elem_index, 64'hAB);
         chk("bp_credit", 64'(o_mask_idx_credit), 64'd0);
         cyc();
      end
      elem_req = 1'b1;
      @(negedge clk);
      chk("bp_e0_index", o_elem_index, 64'hAB);
      chk("bp_e0_last", 64'(o_elem_last), 64'd0);
      cyc();
      @(negedge clk);
      chk("bp_e1_index", o_elem_index, 64'hCD);
      chk("bp_e1_mask", 64'(o_elem_mask), 64'd0);
      chk("bp_e1_last", 64'(o_elem_last), 64'd1);
      chk("bp_cred0", 64'(o_mask_idx_credit), 64'd1);
      cyc();
      elem_req = 1'b0;
      @(negedge clk);
      chk("bp_cred1", 64'(o_mask_idx_credit), 64'd1);
      chk("bp_idle", 64'(o_busy), 64'd0);
      chk("bp_err", 64'(o_err), 64'd0);
      cyc();

      // Overflow: 3 pushes, no pops
      apply_reset();
      push_last = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         push_valid = 1'b1;
         push_item  = {1'b0, 64'(i)};
         cyc();
         if (i == 2) begin
            @(negedge clk);
            chk("ovf_err_before", 64'(o_err), 64'd0);
         end
      end
      push_valid = 1'b0; push_item = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("ovf_err_sticky", 64'(o_err), 64'd1);
         cyc();
      end
      op_start = 1'b1; is_indexed = 1'b1; vl = VLW'(3); elem_req = 1'b1;
      cyc();
      op_start = 1'b0;
      @(negedge clk);
      chk("ovf_e0_index", o_elem_index, 64'd1);
      cyc();
      @(negedge clk);
      chk("ovf_e1_index", o_elem_index, 64'd2);
      cyc();
      @(negedge clk);
      chk("ovf_dropped", 64'(o_elem_valid), 64'd0);
      chk("ovf_busy", 64'(o_busy), 64'd1);
      chk("ovf_err_end", 64'(o_err), 64'd1);

      // vl=0 start, then reset mid-op with one item queued
      apply_reset();
      @(negedge clk);
      chk("rst_err_clear", 64'(o_err), 64'd0);
      op_start = 1'b1; is_indexed = 1'b1; vl = '0;
      cyc();
      op_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("vl0_busy", 64'(o_busy), 64'd0);
         chk("vl0_valid", 64'(o_elem_valid), 64'd0);
         cyc();
      end
      op_start = 1'b1; is_indexed = 1'b1; vl = VLW'(2); elem_req = 1'b0;
      push_valid = 1'b1; push_item = {1'b1, 64'h55}; push_last = 1'b0;
      cyc();
      idle_inputs();
      @(negedge clk);
      chk("mid_valid", 64'(o_elem_valid), 64'd1);
      cyc();
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", 64'(o_elem_valid), 64'd0);
      cyc();
      @(negedge clk);
      chk("mid_rst_busy", 64'(o_busy), 64'd0);
      chk("mid_rst_credit", 64'(o_mask_idx_credit), 64'd0);
      cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_credit", 64'(o_mask_idx_credit), 64'd0);
         chk("post_rst_busy", 64'(o_busy), 64'd0);
         cyc();
      end
      op_start = 1'b1; is_indexed = 1'b1; vl = VLW'(1); elem_req = 1'b1;
      cyc();
      op_start = 1'b0;
      @(negedge clk);
      chk("post_rst_busy_op", 64'(o_busy), 64'd1);
      chk("post_rst_empty", 64'(o_elem_valid), 64'd0);
      chk("post_rst_credit2", 64'(o_mask_idx_credit), 64'd0);
      apply_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
